ex_mem_stage: RTL and testbench

- Pipeline boundary register between the execute unit and the memory stage.
- Captures rd_we / rd_addr / rd_data from the execute unit and presents them to the memory stage one cycle later.
- Uses a valid/ready handshake on both sides, with a one-entry skid buffer so upstream ready is a registered signal.
- Supports a synchronous flush from the control unit. Writes to x0 are suppressed.

---
 rtl/ex_mem_stage.sv | 118 +++++++++++
 tb/tb_ex_mem_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: two-entry skid register with valid/ready on both sides.
// Define EX_MEM_FWD_EN to add the decode forwarding outputs (fwd_we_o/fwd_addr_o/fwd_data_o).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_rd_we_i,
  input  logic [ADDR_W-1:0] ex_rd_addr_i,
  input  logic [DATA_W-1:0] ex_rd_data_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_rd_we_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic [DATA_W-1:0] mem_rd_data_o
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_we_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  logic              mValid_q, mValid_d;
  logic              mWe_q, mWe_d;
  logic [ADDR_W-1:0] mAddr_q, mAddr_d;
  logic [DATA_W-1:0] mData_q, mData_d;

  logic              sValid_q, sValid_d;
  logic              sWe_q, sWe_d;
  logic [ADDR_W-1:0] sAddr_q, sAddr_d;
  logic [DATA_W-1:0] sData_q, sData_d;

  logic accept;
  logic drain;
  logic capWe;

  assign ex_ready_o    = ~sValid_q;
  assign mem_valid_o   = mValid_q;
  assign mem_rd_we_o   = mWe_q;
  assign mem_rd_addr_o = mAddr_q;
  assign mem_rd_data_o = mData_q;

  assign accept = ex_valid_i & ex_ready_o;
  assign drain  = mValid_q & mem_ready_i;
  // Writes aimed at x0 are turned into no-writes at capture time.
  assign capWe  = ex_rd_we_i & (ex_rd_addr_i != '0);

  always_comb begin
    mValid_d = mValid_q;
    mWe_d    = mWe_q;
    mAddr_d  = mAddr_q;
    mData_d  = mData_q;
    sValid_d = sValid_q;
    sWe_d    = sWe_q;
    sAddr_d  = sAddr_q;
    sData_d  = sData_q;

    if (flush_i) begin
      mValid_d = 1'b0;
      sValid_d = 1'b0;
    end else if (sValid_q) begin
      if (drain) begin
        mValid_d = 1'b1;
        mWe_d    = sWe_q;
        mAddr_d  = sAddr_q;
        mData_d  = sData_q;
        sValid_d = 1'b0;
      end
    end else if (!mValid_q || drain) begin
      // M is empty or leaving this cycle, so a new entry goes straight into it.
      mValid_d = accept;
      if (accept) begin
        mWe_d   = capWe;
        mAddr_d = ex_rd_addr_i;
        mData_d = ex_rd_data_i;
      end
    end else if (accept) begin
      sValid_d = 1'b1;
      sWe_d    = capWe;
      sAddr_d  = ex_rd_addr_i;
      sData_d  = ex_rd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mValid_q <= 1'b0;
      mWe_q    <= 1'b0;
      mAddr_q  <= '0;
      mData_q  <= '0;
      sValid_q <= 1'b0;
      sWe_q    <= 1'b0;
      sAddr_q  <= '0;
      sData_q  <= '0;
    end else begin
      mValid_q <= mValid_d;
      mWe_q    <= mWe_d;
      mAddr_q  <= mAddr_d;
      mData_q  <= mData_d;
      sValid_q <= sValid_d;
      sWe_q    <= sWe_d;
      sAddr_q  <= sAddr_d;
      sData_q  <= sData_d;
    end
  end

`ifdef EX_MEM_FWD_EN
  assign fwd_we_o   = mValid_q & mWe_q;
  assign fwd_addr_o = mAddr_q;
  assign fwd_data_o = mData_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed test-plan sequences followed by random traffic,
// checked against a two-deep FIFO reference model kept as a queue.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic        ex_rd_we_i;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_rd_we_o;
  logic [4:0]  mem_rd_addr_o;
  logic [31:0] mem_rd_data_o;
`ifdef EX_MEM_FWD_EN
  logic        fwd_we_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t expQ[$];
  int     compared;
  int     mismatched;
  bit     started;
  bit     wasReset;

  ex_mem_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_rd_we_i    (ex_rd_we_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_rd_data_i  (ex_rd_data_i),
    .mem_valid_o   (mem_valid_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rd_we_o   (mem_rd_we_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_o (mem_rd_data_o)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_we_o      (fwd_we_o),
    .fwd_addr_o    (fwd_addr_o),
    .fwd_data_o    (fwd_data_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, hold them across the next rising edge, then release.
  task automatic applyStimulus(input logic valid, input logic we, input logic [4:0] addr,
                               input logic [31:0] data, input logic memReady, input logic flush);
    ex_valid_i   = valid;
    ex_rd_we_i   = we;
    ex_rd_addr_i = addr;
    ex_rd_data_i = data;
    mem_ready_i  = memReady;
    flush_i      = flush;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of capacity two; entries leave when presented and accepted downstream.
  always @(posedge clk) begin
    entry_t e;
    bit     doDrain;
    bit     doAccept;
    started = 1'b1;
    if (rst) begin
      expQ.delete();
      wasReset = 1'b1;
    end else begin
      wasReset = 1'b0;
      if (flush_i) begin
        expQ.delete();
      end else begin
        doDrain  = (expQ.size() > 0) && mem_ready_i;
        doAccept = ex_valid_i && (expQ.size() < 2);
        if (doDrain) void'(expQ.pop_front());
        if (doAccept) begin
          e.we   = ex_rd_we_i && (ex_rd_addr_i != 5'd0);
          e.addr = ex_rd_addr_i;
          e.data = ex_rd_data_i;
          expQ.push_back(e);
        end
      end
    end
  end

  // Monitor: compares what the DUT presents against the head of the expected queue.
  always @(negedge clk) begin
    if (started) begin
      if (wasReset) begin
        checkOutput("rst_mem_we", 32'(mem_rd_we_o), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_rd_addr_o), 32'd0);
        checkOutput("rst_mem_data", mem_rd_data_o, 32'd0);
`ifdef EX_MEM_FWD_EN
        checkOutput("rst_fwd_addr", 32'(fwd_addr_o), 32'd0);
        checkOutput("rst_fwd_data", fwd_data_o, 32'd0);
`endif
      end
      checkOutput("ex_ready", 32'(ex_ready_o), 32'(expQ.size() < 2));
      checkOutput("mem_valid", 32'(mem_valid_o), 32'(expQ.size() > 0));
      if (expQ.size() > 0) begin
        checkOutput("mem_we", 32'(mem_rd_we_o), 32'(expQ[0].we));
        checkOutput("mem_addr", 32'(mem_rd_addr_o), 32'(expQ[0].addr));
        checkOutput("mem_data", mem_rd_data_o, expQ[0].data);
      end
`ifdef EX_MEM_FWD_EN
      checkOutput("fwd_we", 32'(fwd_we_o), 32'((expQ.size() > 0) && expQ[0].we));
      if (expQ.size() > 0) begin
        checkOutput("fwd_addr", 32'(fwd_addr_o), 32'(expQ[0].addr));
        checkOutput("fwd_data", fwd_data_o, expQ[0].data);
      end
`endif
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    started    = 1'b0;
    wasReset   = 1'b0;
    rst        = 1'b1;
    flush_i    = 1'b0;
    ex_valid_i = 1'b0;
    ex_rd_we_i = 1'b0;
    ex_rd_addr_i = 5'd0;
    ex_rd_data_i = 32'd0;
    mem_ready_i  = 1'b0;

    // Reset for two cycles, then a back-to-back stream with a ready consumer.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    $display("[TB] stream");
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Backpressure fills both slots, then releases in order.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hA5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'hB6, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd8, 32'hC8, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Write to x0 keeps addr/data but clears the write enable.
    $display("[TB] x0");
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Flush with both slots full and a valid input pending.
    $display("[TB] flush");
    applyStimulus(1'b1, 1'b1, 5'd10, 32'h1010, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd11, 32'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Reset mid-operation, then a normal push.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b1, 5'd12, 32'h1212, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd13, 32'h1313, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Forwarding view: hold addr 9 in M, then drain without refill.
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flush and reset.
    $display("[TB] random");
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(($urandom_range(0, 3) != 0),
                    1'($urandom),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                    $urandom,
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 31) == 0));
    end
    rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
